// File: rtl/snake_body.sv
// snake_body: owns the snake for the apple generator and the renderer.
// Holds up to MAX_LEN segment coordinates and moves the head one grid step
// per move tick in the latched direction. Detects apple eating (the snake
// grows), wall collision and self collision.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         level: IDLE -> RUN, OVER -> IDLE (full re-initialisation)
//   btn_*         debounced direction requests
//   appleX/appleY current apple position
//   blockX/blockY flattened segment coordinates, segment i at [10i+9:10i]
//   snake_length  live segment count, 1..MAX_LEN
//   ate           one-cycle pulse on the move that eats the apple
//   game_over     high while in OVER
//   game_won      high in OVER when the snake reached MAX_LEN
//
// state  | meaning
// IDLE   | waiting for start, everything at initial values
// RUN    | tick counter running, snake moves at each terminal count
// OVER   | segments and length frozen until start
module snake_body #(
   parameter int MAX_LEN  = 20,
   parameter int STEP     = 10,
   parameter int X_MIN    = 150,
   parameter int X_MAX    = 780,
   parameter int Y_MIN    = 41,
   parameter int Y_MAX    = 511,
   parameter int X_START  = 460,
   parameter int Y_START  = 271,
   parameter int TICK_DIV = 2500000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic [9:0]            appleX,
   input  logic [9:0]            appleY,
   output logic [MAX_LEN*10-1:0] blockX,
   output logic [MAX_LEN*10-1:0] blockY,
   output logic [4:0]            snake_length,
   output logic                  ate,
   output logic                  game_over,
   output logic                  game_won
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;

   // Opposite directions differ only in bit 0.
   localparam logic [1:0] D_RIGHT = 2'd0;
   localparam logic [1:0] D_LEFT  = 2'd1;
   localparam logic [1:0] D_UP    = 2'd2;
   localparam logic [1:0] D_DOWN  = 2'd3;

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [1:0]    state;
   logic [1:0]    dir;
   logic [1:0]    dir_next;
   logic [1:0]    req;
   logic          req_valid;
   logic [CW-1:0] tick_cnt;
   logic [9:0]    seg_x [MAX_LEN];
   logic [9:0]    seg_y [MAX_LEN];
   logic [10:0]   nh_x;
   logic [10:0]   nh_y;
   logic          move;
   logic          wall_hit;
   logic          self_hit;
   logic          eat;
   logic [4:0]    new_len;

   always_comb begin
      req       = D_RIGHT;
      req_valid = 1'b1;
      if (btn_up)         req = D_UP;
      else if (btn_down)  req = D_DOWN;
      else if (btn_left)  req = D_LEFT;
      else if (btn_right) req = D_RIGHT;
      else                req_valid = 1'b0;

      dir_next = dir;
      if (req_valid && !((snake_length > 5'd1) && (req == {dir[1], ~dir[0]})))
         dir_next = req;
   end

   // Next head; a step below zero wraps to a large value and reads as a wall hit.
   always_comb begin
      nh_x = {1'b0, seg_x[0]};
      nh_y = {1'b0, seg_y[0]};
      case (dir)
         D_RIGHT: nh_x = {1'b0, seg_x[0]} + 11'(STEP);
         D_LEFT:  nh_x = {1'b0, seg_x[0]} - 11'(STEP);
         D_UP:    nh_y = {1'b0, seg_y[0]} - 11'(STEP);
         default: nh_y = {1'b0, seg_y[0]} + 11'(STEP);
      endcase

      wall_hit = (nh_x < 11'(X_MIN)) || (nh_x > 11'(X_MAX)) ||
                 (nh_y < 11'(Y_MIN)) || (nh_y > 11'(Y_MAX));

      self_hit = 1'b0;
      for (int j = 1; j < MAX_LEN; j++) begin
         if ((5'(j) < snake_length) && ({1'b0, seg_x[j]} == nh_x) &&
             ({1'b0, seg_y[j]} == nh_y))
            self_hit = 1'b1;
      end

      eat     = (nh_x == {1'b0, appleX}) && (nh_y == {1'b0, appleY});
      new_len = snake_length + {4'd0, eat};
      move    = (state == S_RUN) && (tick_cnt == CW'(TICK_DIV - 1));
   end

   always_ff @(posedge clk) begin
      if (reset || ((state == S_OVER) && start)) begin
         state        <= S_IDLE;
         dir          <= D_RIGHT;
         tick_cnt     <= '0;
         snake_length <= 5'd1;
         ate          <= 1'b0;
         game_over    <= 1'b0;
         game_won     <= 1'b0;
         seg_x[0]     <= 10'(X_START);
         seg_y[0]     <= 10'(Y_START);
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= '0;
            seg_y[i] <= '0;
         end
      end else begin
         ate <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  tick_cnt <= '0;
               end
            end
            S_RUN: begin
               dir <= dir_next;
               if (move) begin
                  tick_cnt <= '0;
                  if (wall_hit || self_hit) begin
                     state     <= S_OVER;
                     game_over <= 1'b1;
                  end else begin
                     // Shift; the old tail survives only when the snake grows.
                     for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= (5'(i) < new_len) ? seg_x[i-1] : '0;
                        seg_y[i] <= (5'(i) < new_len) ? seg_y[i-1] : '0;
                     end
                     seg_x[0]     <= nh_x[9:0];
                     seg_y[0]     <= nh_y[9:0];
                     snake_length <= new_len;
                     ate          <= eat;
                     if (new_len == 5'(MAX_LEN)) begin
                        state     <= S_OVER;
                        game_over <= 1'b1;
                        game_won  <= 1'b1;
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_OVER:  ;
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
      assign blockX[10*g +: 10] = seg_x[g];
      assign blockY[10*g +: 10] = seg_y[g];
   end

endmodule

// File: tb/tb_snake_body.sv
module tb_snake_body;
   localparam int ML = 20;
   localparam int TD = 4;

   logic              clk = 1'b0;
   logic              reset, start, bu, bd, bl, br;
   logic [9:0]        ax, ay;
   logic [ML*10-1:0]  bx, by;
   logic [4:0]        len;
   logic              ate, gover, gwon;

   always #5 clk = ~clk;

   snake_body #(.MAX_LEN(ML), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .start(start),
      .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
      .appleX(ax), .appleY(ay),
      .blockX(bx), .blockY(by), .snake_length(len),
      .ate(ate), .game_over(gover), .game_won(gwon));

   int nvec = 0;
   int nerr = 0;

   // Reference model: the snake is a queue of points, head at the front.
   // mode 0 = waiting, 1 = playing, 2 = ended. dir 0 up, 1 down, 2 left, 3 right.
   int qx[$];
   int qy[$];
   int m_mode, m_cnt, m_dir, m_moves;
   bit m_ate, m_over, m_won;

   function automatic void m_init();
      m_mode = 0; m_cnt = 0; m_dir = 3;
      qx = {460}; qy = {271};
      m_ate = 0; m_over = 0; m_won = 0;
   endfunction

   function automatic void m_edge();
      int req, nd, nx, ny;
      bit hit;
      m_ate = 0;
      if (reset) begin m_init(); return; end
      if (m_mode == 0) begin
         if (start) begin m_mode = 1; m_cnt = 0; end
      end else if (m_mode == 2) begin
         if (start) m_init();
      end else begin
         req = bu ? 0 : bd ? 1 : bl ? 2 : br ? 3 : -1;
         nd  = m_dir;
         if (req >= 0 && !(qx.size() > 1 && ((req == 0 && m_dir == 1) || (req == 1 && m_dir == 0) ||
             (req == 2 && m_dir == 3) || (req == 3 && m_dir == 2))))
            nd = req;
         if (m_cnt == TD - 1) begin
            nx = qx[0] + (m_dir == 2 ? -10 : m_dir == 3 ? 10 : 0);
            ny = qy[0] + (m_dir == 0 ? -10 : m_dir == 1 ? 10 : 0);
            hit = (nx < 150) || (nx > 780) || (ny < 41) || (ny > 511);
            for (int j = 1; j < qx.size(); j++)
               if (qx[j] == nx && qy[j] == ny) hit = 1;
            m_moves++;
            if (hit) begin
               m_mode = 2; m_over = 1;
            end else begin
               qx.push_front(nx); qy.push_front(ny);
               if (nx == int'(ax) && ny == int'(ay)) m_ate = 1;
               else begin void'(qx.pop_back()); void'(qy.pop_back()); end
               if (qx.size() == ML) begin m_mode = 2; m_over = 1; m_won = 1; end
            end
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         m_dir = nd;
      end
   endfunction

   function automatic logic [ML*10-1:0] mflat(input bit isy);
      logic [ML*10-1:0] v = '0;
      for (int i = 0; i < qx.size(); i++) v[10*i +: 10] = isy ? 10'(qy[i]) : 10'(qx[i]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; start = 0; {bu, bd, bl, br} = 4'b0; ax = 0; ay = 0;
      tick(); tick();
      reset = 0;
   endtask

   task automatic run_moves(input int n);
      int target = m_moves + n;
      for (int c = 0; c < 16 * n && m_moves < target; c++) tick();
      nvec++;
      if (m_moves < target) begin
         nerr++;
         $display("FAIL move_timeout: moves=%0d required=%0d", m_moves, target);
      end
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if (bx[9:0] !== 10'd460 || by[9:0] !== 10'd271 || len !== 5'd1 || ate !== 0 ||
          gover !== 0 || gwon !== 0 || bx[ML*10-1:10] !== '0 || by[ML*10-1:10] !== '0) begin
         nerr++;
         $display("FAIL reset: head=(%0d,%0d) len=%0d ate=%b over=%b won=%b, required (460,271) 1 0 0 0",
                  bx[9:0], by[9:0], len, ate, gover, gwon);
      end
   endtask

   task automatic test_straight();
      int k = 0;
      int mv;
      start = 1; tick(); start = 0;
      for (int c = 0; c < 12; c++) begin
         mv = m_moves;
         tick();
         if (m_moves != mv) begin
            k++;
            nvec++;
            if (bx[9:0] !== 10'(460 + 10 * k) || by[9:0] !== 10'd271 || len !== 5'd1 || ate !== 0) begin
               nerr++;
               $display("FAIL straight: move %0d head=(%0d,%0d) len=%0d ate=%b, required (%0d,271) 1 0",
                        k, bx[9:0], by[9:0], len, ate, 460 + 10 * k);
            end
         end
      end
      nvec++;
      if (k != 3) begin
         nerr++;
         $display("FAIL straight_count: moves=%0d required=3", k);
      end
   endtask

   task automatic test_eat_and_steer();
      int pulses = 0;
      do_reset();
      ax = 480; ay = 271;
      start = 1; tick(); start = 0;
      for (int c = 0; c < 8; c++) begin tick(); if (ate === 1'b1) pulses++; end
      nvec++;
      if (len !== 5'd2 || pulses != 1 || bx[19:0] !== {10'd470, 10'd480} ||
          by[19:0] !== {10'd271, 10'd271} || bx[ML*10-1:20] !== '0 || by[ML*10-1:20] !== '0) begin
         nerr++;
         $display("FAIL eat: len=%0d pulses=%0d seg0=(%0d,%0d) seg1=(%0d,%0d), required 2 1 (480,271) (470,271)",
                  len, pulses, bx[9:0], by[9:0], bx[19:10], by[19:10]);
      end
      ax = 490;
      run_moves(1);
      bl = 1; run_moves(1); bl = 0;
      nvec++;
      if (len !== 5'd3 || bx[9:0] !== 10'd500 || by[9:0] !== 10'd271) begin
         nerr++;
         $display("FAIL reverse_ignored: len=%0d head=(%0d,%0d), required 3 (500,271)", len, bx[9:0], by[9:0]);
      end
      bu = 1; br = 1; run_moves(1); bu = 0; br = 0;
      nvec++;
      if (bx[9:0] !== 10'd500 || by[9:0] !== 10'd261 || bx !== mflat(0) || by !== mflat(1)) begin
         nerr++;
         $display("FAIL up_priority: head=(%0d,%0d), required (500,261)", bx[9:0], by[9:0]);
      end
      ax = 0; ay = 0;
   endtask

   task automatic test_wall();
      do_reset();
      start = 1; tick(); start = 0;
      for (int c = 0; c < 400 && m_over == 0; c++) tick();
      nvec++;
      if (gover !== 1 || gwon !== 0 || bx[9:0] !== 10'd780 || len !== 5'd1) begin
         nerr++;
         $display("FAIL wall: over=%b won=%b head x=%0d len=%0d, required 1 0 780 1", gover, gwon, bx[9:0], len);
      end
      for (int c = 0; c < 9; c++) tick();
      nvec++;
      if (gover !== 1 || bx[9:0] !== 10'd780 || by[9:0] !== 10'd271) begin
         nerr++;
         $display("FAIL over_frozen: over=%b head=(%0d,%0d), required 1 (780,271)", gover, bx[9:0], by[9:0]);
      end
      start = 1; tick(); start = 0;
      nvec++;
      if (gover !== 0 || bx[9:0] !== 10'd460 || by[9:0] !== 10'd271 || len !== 5'd1) begin
         nerr++;
         $display("FAIL restart: over=%b head=(%0d,%0d) len=%0d, required 0 (460,271) 1",
                  gover, bx[9:0], by[9:0], len);
      end
   endtask

   task automatic test_self_collision();
      logic [ML*10-1:0] sx, sy;
      do_reset();
      start = 1; tick(); start = 0;
      for (int k = 0; k < 4; k++) begin
         ax = 10'(qx[0] + 10); ay = 10'(qy[0]);
         run_moves(1);
      end
      ax = 0; ay = 0;
      bd = 1; run_moves(1); bd = 0;
      bl = 1; run_moves(1); bl = 0;
      sx = bx; sy = by;
      bu = 1; run_moves(1); bu = 0;
      nvec++;
      if (gover !== 1 || gwon !== 0 || len !== 5'd5 || bx !== sx || by !== sy) begin
         nerr++;
         $display("FAIL self: over=%b won=%b len=%0d head=(%0d,%0d), required 1 0 5 (490,281) unchanged",
                  gover, gwon, len, bx[9:0], by[9:0]);
      end
   endtask

   task automatic test_win();
      do_reset();
      start = 1; tick(); start = 0;
      for (int k = 0; k < 19; k++) begin
         ax = 10'(qx[0] + 10); ay = 10'(qy[0]);
         run_moves(1);
      end
      nvec++;
      if (gover !== 1 || gwon !== 1 || len !== 5'd20 || bx[9:0] !== 10'd650 || bx[199:190] !== 10'd460) begin
         nerr++;
         $display("FAIL win: over=%b won=%b len=%0d head x=%0d tail x=%0d, required 1 1 20 650 460",
                  gover, gwon, len, bx[9:0], bx[199:190]);
      end
      ax = 0; ay = 0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      ax = 470; ay = 271;
      start = 1; tick(); start = 0;
      for (int c = 0; c < 40 && m_cnt != TD - 1; c++) tick();
      reset = 1; tick(); reset = 0;
      nvec++;
      if (bx[9:0] !== 10'd460 || by[9:0] !== 10'd271 || len !== 5'd1 || ate !== 0 || gover !== 0 ||
          bx[ML*10-1:10] !== '0) begin
         nerr++;
         $display("FAIL mid_reset: head=(%0d,%0d) len=%0d ate=%b over=%b, required (460,271) 1 0 0",
                  bx[9:0], by[9:0], len, ate, gover);
      end
      ax = 0; ay = 0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         start = ($urandom_range(0, 29) == 0);
         {bu, bd, bl, br} = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         if ($urandom_range(0, 2) == 0) begin
            ax = 10'(qx[0] + (m_dir == 2 ? -10 : m_dir == 3 ? 10 : 0));
            ay = 10'(qy[0] + (m_dir == 0 ? -10 : m_dir == 1 ? 10 : 0));
         end else if ($urandom_range(0, 3) == 0) begin
            ax = 10'(150 + 10 * $urandom_range(0, 63));
            ay = 10'(41 + 10 * $urandom_range(0, 47));
         end
         tick();
         nvec++;
         if (bx !== mflat(0) || by !== mflat(1) || len !== 5'(qx.size()) ||
             ate !== m_ate || gover !== m_over || gwon !== m_won) begin
            nerr++;
            $display("FAIL random c=%0d: len=%0d ate=%b over=%b won=%b head=(%0d,%0d), required %0d %b %b %b (%0d,%0d)",
                     c, len, ate, gover, gwon, bx[9:0], by[9:0], qx.size(), m_ate, m_over, m_won, qx[0], qy[0]);
         end
      end
      reset = 0; start = 0; {bu, bd, bl, br} = 4'b0;
   endtask

   initial begin
      m_moves = 0;
      m_init();
      test_reset();
      test_straight();
      test_eat_and_steer();
      test_wall();
      test_self_collision();
      test_win();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Upstream stage of the apple generator: owns the snake.
- Holds up to MAX_LEN segment coordinates and advances the snake one grid step per move tick in the latched direction.
- Detects apple eating (grows length), wall collision and self collision.
- Drives the flattened segment X/Y buses and snake_length consumed by the apple generator and the VGA renderer.

Parameters:
- MAX_LEN, 20, maximum segment count (matches the apple generator's 20-entry overlap check)
- STEP, 10, grid pitch in pixels
- X_MIN, 150, leftmost legal head X
- X_MAX, 780, rightmost legal head X
- Y_MIN, 41, topmost legal head Y
- Y_MAX, 511, bottom legal head Y
- X_START, 460, head X after reset/restart (on grid)
- Y_START, 271, head Y after reset/restart (on grid)
- TICK_DIV, 2500000, clk cycles per move (10 moves/s at 25 MHz)

Ports:
- clk  in  1  pixel/system clock, rising edge; the only clock
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- start  in  1  level; starts play from IDLE, restarts from OVER
- btn_up, btn_down, btn_left, btn_right  in  1 each  direction requests, already debounced
- appleX  in  10  current apple X
- appleY  in  10  current apple Y
- blockX  out  MAX_LEN*10  segment i X at bits [10i+9:10i]; segment 0 = head
- blockY  out  MAX_LEN*10  segment i Y, same packing
- snake_length  out  5  live segment count, 1..MAX_LEN
- ate  out  1  one-cycle pulse when the head lands on the apple
- game_over  out  1  high while in OVER
- game_won  out  1  high in OVER when the end cause was reaching MAX_LEN

Behaviour:
- FSM states: IDLE, RUN, OVER. All outputs are registered.
- Reset values:
  - state = IDLE; dir = RIGHT; snake_length = 1.
  - Segment 0 = (X_START, Y_START); segments 1..MAX_LEN-1 = (0,0). 0 is off-grid and never matches an apple.
  - ate = 0; game_over = 0; game_won = 0; tick counter = 0.
- IDLE:
  - Outputs hold their reset state.
  - start=1 -> RUN on the next edge; tick counter cleared.
- Direction latch (every RUN cycle):
  - Priority up > down > left > right when several buttons are high.
  - A request opposite to the current dir is ignored when snake_length > 1, and allowed when length = 1.
  - With no button high, dir holds.
  - dir is applied only at a move.
- Tick counter: in RUN, counts 0..TICK_DIV-1 and wraps. A move occurs in the cycle where the count = TICK_DIV-1. The counter is frozen in IDLE and OVER.
- Move evaluation (combinational on the move cycle, committed on that edge):
  - nh = head ± STEP on the axis given by dir.
  - Wall: nh outside [X_MIN,X_MAX] x [Y_MIN,Y_MAX] -> OVER; segments are not updated.
  - Self: nh equals segment j for any j in 1..snake_length-1 (tail included) -> OVER; no update.
  - Wall and self together -> OVER; game_won = 0.
  - Otherwise shift: seg[i] <= seg[i-1] for i = 1..MAX_LEN-1; seg[0] <= nh. Segments at index ≥ the new length are then forced to (0,0).
  - Eat: nh == (appleX, appleY) and no collision. snake_length increments by 1 in the same edge, so the old tail is kept as the new last segment. ate = 1 for exactly that one cycle.
  - If the incremented length equals MAX_LEN -> OVER with game_won = 1.
  - snake_length never exceeds MAX_LEN and never wraps.
- OVER:
  - Segments and length freeze; game_over = 1.
  - start=1 -> IDLE with the full reset initialisation (same values as reset). game_over and game_won clear.
- Latency: blockX, blockY, snake_length and ate change exactly 1 clk after the move cycle. The apple generator sees the new length on the following edge.
- reset=1 on any cycle, including mid-move or in OVER, overrides everything. The next state is the reset state.
- start held high in RUN has no effect.

Test Plan (TICK_DIV=4 in simulation):
- Reset, then start=1 for 1 cycle, no buttons -> head moves right 10 px every 4 clk: (470,271), (480,271), (490,271); snake_length = 1; ate = 0.
- Apple at (480,271), from start -> at the 2nd move snake_length = 2, ate pulses exactly 1 cycle, seg0 = (480,271), seg1 = (470,271); seg2..19 = 0.
- Length 3 moving right, btn_left=1 -> ignored, head continues +10 X. Then btn_up with btn_right both high -> up wins, next head Y = previous Y - 10.
- Drive the head to X = 780 moving right -> next move cycle enters OVER, game_over = 1, head stays at 780, counter frozen. Then start=1 -> IDLE with head (460,271), length 1.
- Length-5 snake steered right, down, left, up into its own body -> OVER on the colliding move, segments unchanged from before that move, game_won = 0.
- Eat repeatedly until length 20 -> game_won = 1 and game_over = 1. Assert reset mid-RUN in a separate run -> next cycle shows all reset values.
